// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encoding,
// datapath width and the architectural reset/NOP constants.
package fetch_pc_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Redirect arbitration for the fetch PC: jump beats branch, targets are
// word-aligned, and bit[1] of the raw target is reported as misaligned.
module pc_next_sel
   import fetch_pc_unit_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   output logic            redirect,
   output logic [XLEN-1:0] target,
   output logic            target_misalign,
   output logic [XLEN-1:0] pc_plus4
);

   logic [XLEN-1:0] raw_target;

   always_comb begin
      raw_target = branch_target;
      if (jump) begin
         raw_target = jump_target;
      end
   end

   assign redirect        = jump | branch_taken;
   assign target          = raw_target & ~32'h0000_0003;
   assign target_misalign = raw_target[1];
   assign pc_plus4        = pc + 32'd4;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC and instruction-fetch sequencer: one outstanding imem
// request at a time, one instruction presented to decode at a time.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] instr_pc,
   output logic            misalign,
   output logic [1:0]      fetch_state
);

   // Handshakes: imem_req stays high with imem_addr frozen until the single
   // cycle imem_ack; decode takes instr_out/instr_pc in a cycle where both
   // instr_valid and instr_ready are high, and nothing changes while it stalls.

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pending;
   logic            redirect;
   logic [XLEN-1:0] target;
   logic            target_misalign;
   logic [XLEN-1:0] pc_plus4;

   pc_next_sel u_pc_next_sel (
      .pc              (pc),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .jump            (jump),
      .jump_target     (jump_target),
      .redirect        (redirect),
      .target          (target),
      .target_misalign (target_misalign),
      .pc_plus4        (pc_plus4)
   );

   assign imem_addr   = pc;
   assign fetch_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pending     <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr_out   <= NOP_INSTR;
         instr_pc    <= '0;
         misalign    <= 1'b0;
      end else begin
         misalign <= redirect & target_misalign;
         case (state)
            FETCH: begin
               if (!imem_req) begin
                  // First cycle out of reset: nothing is outstanding yet.
                  imem_req <= 1'b1;
                  if (redirect) begin
                     pc <= target;
                  end
               end else if (imem_ack && !redirect) begin
                  instr_out   <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc_plus4;
                  imem_req    <= 1'b0;
                  state       <= VALID;
               end else if (imem_ack) begin
                  pc <= target;
               end else if (redirect) begin
                  pending <= target;
                  state   <= DRAIN;
               end
            end
            VALID: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  instr_out   <= NOP_INSTR;
                  pc          <= target;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end
            end
            DRAIN: begin
               // The stale request must still complete; its data is dropped.
               if (imem_ack) begin
                  pc    <= redirect ? target : pending;
                  state <= FETCH;
               end else if (redirect) begin
                  pending <= target;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule
